// File: rtl/polar_iq_frame_source.sv
// -----------------------------------------------------------------------------
// polar_iq_frame_source
//
// Converts one polar sample (10-bit magnitude, 10-bit phase) at a time into a
// 14-bit signed I/Q pair using an iterative rotation-mode CORDIC. It then
// groups the results into frames of N samples, so they line up with the
// dataset size of the downstream sort/cluster/classify chain. It serves as an
// on-chip stimulus / loopback source for the ini/inq inputs of the
// classification top level.
//
// Parameters:
//   N      samples per frame (must match the downstream dataset size)
//   ITERS  CORDIC micro-rotations, legal range 8..15
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   in_valid     polar sample present (must be held until in_ready)
//   in_ready     block can accept a sample (IDLE only)
//   mag          unsigned magnitude
//   phase        unsigned phase, LSB = 2*pi/1024, wraps at full circle
//   out_valid    I/Q sample valid (HOLD state)
//   out_ready    downstream accepts the sample
//   out_i        signed I, nominal mag*8*cos(phase), range [-8191,+8191]
//   out_q        signed Q, nominal mag*8*sin(phase), range [-8191,+8191]
//   frame_start  with out_valid: sample index 0 of the frame
//   frame_last   with out_valid: sample index N-1 of the frame
//   busy         high in any state other than IDLE
//
// Build option:
//   P2R_ROUND_EN  defined   -> round half toward +inf on the final >>>3
//                 undefined -> plain arithmetic truncation (toward -inf)
// -----------------------------------------------------------------------------
module polar_iq_frame_source #(
    parameter int N     = 1000,
    parameter int ITERS = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9:0]         mag,
    input  logic [9:0]         phase,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [13:0] out_i,
    output logic signed [13:0] out_q,
    output logic               frame_start,
    output logic               frame_last,
    output logic               busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = 4;                         // holds 0..ITERS, ITERS <= 15
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERS);
    localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);
    localparam logic [14:0]   INV_K     = 15'd19899; // 1/1.64676 in Q0.15

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IW-1:0]      r_iter;
    logic [CW-1:0]      r_count;
    logic signed [17:0] r_x;
    logic signed [17:0] r_y;
    logic signed [15:0] r_z;
    logic signed [13:0] r_out_i;
    logic signed [13:0] r_out_q;

    // -------------------------------------------------------------------------
    // atan(2^-i) in angle units where the full circle is 65536.
    // -------------------------------------------------------------------------
    function automatic logic signed [15:0] atan_lut(input logic [IW-1:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'sd8192;
            4'd1:    atan_lut = 16'sd4836;
            4'd2:    atan_lut = 16'sd2555;
            4'd3:    atan_lut = 16'sd1297;
            4'd4:    atan_lut = 16'sd651;
            4'd5:    atan_lut = 16'sd326;
            4'd6:    atan_lut = 16'sd163;
            4'd7:    atan_lut = 16'sd81;
            4'd8:    atan_lut = 16'sd41;
            4'd9:    atan_lut = 16'sd20;
            4'd10:   atan_lut = 16'sd10;
            4'd11:   atan_lut = 16'sd5;
            4'd12:   atan_lut = 16'sd3;
            4'd13:   atan_lut = 16'sd1;
            4'd14:   atan_lut = 16'sd1;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Drop the 3 guard bits (truncate or round) and clamp to a symmetric
    // range so that -8192 is never produced.
    // -------------------------------------------------------------------------
    function automatic logic signed [13:0] scale_sat(input logic signed [17:0] v);
        logic signed [18:0] t;
        logic signed [15:0] s;
`ifdef P2R_ROUND_EN
        t = 19'(v) + 19'sd4;
`else
        t = 19'(v);
`endif
        s = 16'(t >>> 3);
        if (s > 16'sd8191) begin
            scale_sat = 14'sd8191;
        end else if (s < -16'sd8191) begin
            scale_sat = -14'sd8191;
        end else begin
            scale_sat = 14'(s);
        end
    endfunction

    // -------------------------------------------------------------------------
    // Quadrant pre-rotation and initial vector.
    // For phases in [90deg, 270deg), start from the negative x axis and
    // rotate by (phase - 180deg). This keeps the residual angle inside +/-90deg,
    // which lies within the CORDIC convergence range.
    // -------------------------------------------------------------------------
    logic               w_flip;
    logic [9:0]         w_resid;
    logic [24:0]        w_prod;
    logic signed [17:0] w_x0_mag;
    logic signed [17:0] w_x0;
    logic signed [15:0] w_z0;

    assign w_flip   = phase[9] ^ phase[8];
    assign w_resid  = w_flip ? (phase - 10'd512) : phase;
    // mag*8*INV_K in Q0.15, kept with 3 fractional bits: (mag*INV_K) >> 9.
    assign w_prod   = {15'd0, mag} * {10'd0, INV_K};
    assign w_x0_mag = 18'(w_prod >> 9);
    assign w_x0     = w_flip ? -w_x0_mag : w_x0_mag;
    // The residual is read as signed 10 bits; shifting it by 6 maps 1024 -> 65536.
    assign w_z0     = signed'({w_resid, 6'b000000});

    // -------------------------------------------------------------------------
    // One micro-rotation, selected by the sign of the remaining angle.
    // -------------------------------------------------------------------------
    logic signed [17:0] w_xs;
    logic signed [17:0] w_ys;
    logic signed [15:0] w_atan;
    logic signed [17:0] w_x_rot;
    logic signed [17:0] w_y_rot;
    logic signed [15:0] w_z_rot;

    assign w_xs   = r_x >>> r_iter;
    assign w_ys   = r_y >>> r_iter;
    assign w_atan = atan_lut(r_iter);

    always_comb begin
        if (!r_z[15]) begin
            w_x_rot = r_x - w_ys;
            w_y_rot = r_y + w_xs;
            w_z_rot = r_z - w_atan;
        end else begin
            w_x_rot = r_x + w_ys;
            w_y_rot = r_y - w_xs;
            w_z_rot = r_z + w_atan;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so that every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = S_ROT;
                end
            end
            S_ROT: begin
                // ITERS rotation cycles, then one more cycle to register outputs.
                if (r_iter == LAST_ITER) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers: iteration count, frame counter and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iter  <= '0;
            r_count <= '0;
            r_out_i <= '0;
            r_out_q <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_iter <= '0;
                    end
                end
                S_ROT: begin
                    if (r_iter == LAST_ITER) begin
                        r_out_i <= scale_sat(r_x);
                        r_out_q <= scale_sat(r_y);
                    end else begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_count <= (r_count == LAST_CNT) ? '0 : r_count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // CORDIC datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the x/y/z working registers have no reset. Each sample loads them
    // before they are read, and a reset returns the FSM to IDLE, where their
    // contents are ignored.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid) begin
            r_x <= w_x0;
            r_y <= '0;
            r_z <= w_z0;
        end else if (r_state == S_ROT && r_iter != LAST_ITER) begin
            r_x <= w_x_rot;
            r_y <= w_y_rot;
            r_z <= w_z_rot;
        end
    end

    assign out_i       = r_out_i;
    assign out_q       = r_out_q;
    assign frame_start = out_valid && (r_count == '0);
    assign frame_last  = out_valid && (r_count == LAST_CNT);

endmodule

// File: tb/tb_polar_iq_frame_source.sv
// -----------------------------------------------------------------------------
// tb_polar_iq_frame_source
//
// Directed bench for polar_iq_frame_source, built with N=4 so that frame
// boundaries occur often. Expected I/Q values are nominal mag*8*cos/sin, with
// small tolerances. Framing flags are predicted from a bench-side sample
// index that restarts at every reset.
// -----------------------------------------------------------------------------
module tb_polar_iq_frame_source;

    localparam int NF     = 4;
    localparam int ITERS  = 14;
    localparam int BOUND  = 200;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [9:0]         mag;
    logic [9:0]         phase;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] out_i;
    logic signed [13:0] out_q;
    logic               frame_start;
    logic               frame_last;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_idx  = 0;   // index of the next sample within the current frame
    int n_smp    = 0;

    polar_iq_frame_source #(
        .N     (NF),
        .ITERS (ITERS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mag         (mag),
        .phase       (phase),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_i       (out_i),
        .out_q       (out_q),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // One-cycle synchronous reset; the caller then stands 1 time unit past an edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_idx = 0;
    endtask

    // Send one sample, check the latency and framing flags, then return the I/Q
    // outputs and complete the handshake.
    task automatic xfer(input logic [9:0] m, input logic [9:0] p,
                        output int oi, output int oq);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < BOUND) begin
            @(posedge clk); #1;
            w++;
        end
        check($sformatf("in_ready_%0d", n_smp), int'(in_ready), 1, 0);
        mag = m; phase = p; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency_%0d", n_smp), lat, ITERS + 1, 0);
        oi = int'(out_i);
        oq = int'(out_q);
        check($sformatf("fstart_%0d", n_smp), int'(frame_start),
              (exp_idx % NF == 0) ? 1 : 0, 0);
        check($sformatf("flast_%0d", n_smp), int'(frame_last),
              (exp_idx % NF == NF - 1) ? 1 : 0, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("idle_after_%0d", n_smp), int'(busy), 0, 0);
        exp_idx++;
        n_smp++;
    endtask

    // Directed vectors: magnitude, phase, expected I, expected Q, tolerance.
    typedef struct {
        logic [9:0] m;
        logic [9:0] p;
        int         ei;
        int         eq;
        int         tol;
    } vec_t;

    vec_t vecs[8] = '{
        '{10'd1000, 10'd0,    8000,     0, 2},
        '{10'd1000, 10'd256,     0,  8000, 2},
        '{10'd1000, 10'd512, -8000,     0, 2},
        '{10'd1000, 10'd768,     0, -8000, 2},
        '{10'd1023, 10'd128,  5787,  5787, 3},
        '{10'd0,    10'd0,       0,     0, 0},
        '{10'd0,    10'd300,     0,     0, 0},
        '{10'd0,    10'd1023,    0,     0, 0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oi;
        int oq;
        int oi0;
        int oq0;
        int bad;
        int hs;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mag = '0; phase = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", int'(out_valid),   0, 0);
        check("rst_in_ready",  int'(in_ready),    1, 0);
        check("rst_busy",      int'(busy),        0, 0);
        check("rst_fstart",    int'(frame_start), 0, 0);
        check("rst_flast",     int'(frame_last),  0, 0);
        check("rst_out_i",     int'(out_i),       0, 0);
        check("rst_out_q",     int'(out_q),       0, 0);

        // Axis points, the 45 degree point and zero magnitude
        foreach (vecs[k]) begin
            xfer(vecs[k].m, vecs[k].p, oi, oq);
            check($sformatf("vec%0d_i", k), oi, vecs[k].ei, vecs[k].tol);
            check($sformatf("vec%0d_q", k), oq, vecs[k].eq, vecs[k].tol);
        end

        // Backpressure: out_ready is held low for 50 cycles while in_valid pulses
        mag = 10'd700; phase = 10'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bad = 0;
        while (!out_valid && bad < BOUND) begin
            @(posedge clk); #1;
            bad++;
        end
        check("bp_latency", bad, ITERS + 1, 0);
        oi0 = int'(out_i);
        oq0 = int'(out_q);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            in_valid = c[0];
            mag      = 10'(c * 13);
            phase    = 10'(c * 37);
            @(posedge clk); #1;
            if (!out_valid || in_ready || !busy || int'(out_i) != oi0 || int'(out_q) != oq0)
                bad++;
        end
        in_valid = 1'b0;
        check("bp_stable_cycles_bad", bad, 0, 0);
        out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < ITERS + 6; c++) begin
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("bp_handshakes", hs, 1, 0);

        // Framing: 9 samples after a reset -> starts at 0,4,8 and lasts at 3,7
        do_reset();
        for (int s = 0; s < 9; s++) begin
            xfer(10'd500, 10'(s * 100), oi, oq);
        end

        // Reset 5 cycles into ROT, with the frame counter at a nonzero value
        mag = 10'd900; phase = 10'd200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_abort_busy", int'(busy), 1, 0);
        do_reset();
        check("abort_out_valid", int'(out_valid), 0, 0);
        check("abort_busy",      int'(busy),      0, 0);
        check("abort_in_ready",  int'(in_ready),  1, 0);
        xfer(10'd1000, 10'd512, oi, oq);
        check("post_abort_i", oi, -8000, 2);
        check("post_abort_q", oq, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
